// File: rtl/audio_adc_rx.sv
// Codec ADC serial receiver: oversamples BCLK/LRCK/ADCDAT and emits stereo sample pairs.
// Define AUD_RX_I2S_EN for Philips I2S framing; left-justified framing otherwise.
module audio_adc_rx #(
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  iCLK,
  input  logic                  iRST_N,
  input  logic                  iAUD_BCK,
  input  logic                  iAUD_LRCK,
  input  logic                  iAUD_ADCDAT,
  output logic [DATA_WIDTH-1:0] oAUD_inL,
  output logic [DATA_WIDTH-1:0] oAUD_inR,
  output logic                  oValid,
  output logic                  oFrameErr
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    ALIGN   = 3'd0,
    SHIFT_L = 3'd1,
    SHIFT_R = 3'd2,
    WAIT_L  = 3'd3,
    WAIT_R  = 3'd4
  } state_t;

  logic [SYNC_STAGES-1:0] bck_sync_r, lrck_sync_r, dat_sync_r;
  logic                   bck_prev_r, lrck_prev_r;
  logic                   bck_rise_r, lrck_rise_r, lrck_fall_r, dat_r;

  state_t                 state_r;
  logic [DATA_WIDTH-1:0]  shift_r, hold_l_r, hold_r_r;
  logic [CW-1:0]          cnt_r;
  logic                   skip_r, bad_r;

  logic [DATA_WIDTH-1:0]  shift_word_s;
  logic                   start_l_s, start_r_s, enter_skip_s;
  logic [CW-1:0]          enter_cnt_s;

  // Input synchronizers plus registered edge strobes; data is delayed to line up with them
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      bck_sync_r  <= '0;
      lrck_sync_r <= '0;
      dat_sync_r  <= '0;
      bck_prev_r  <= 1'b0;
      lrck_prev_r <= 1'b0;
      bck_rise_r  <= 1'b0;
      lrck_rise_r <= 1'b0;
      lrck_fall_r <= 1'b0;
      dat_r       <= 1'b0;
    end else begin
      bck_sync_r  <= {bck_sync_r[SYNC_STAGES-2:0], iAUD_BCK};
      lrck_sync_r <= {lrck_sync_r[SYNC_STAGES-2:0], iAUD_LRCK};
      dat_sync_r  <= {dat_sync_r[SYNC_STAGES-2:0], iAUD_ADCDAT};
      bck_prev_r  <= bck_sync_r[SYNC_STAGES-1];
      lrck_prev_r <= lrck_sync_r[SYNC_STAGES-1];
      bck_rise_r  <= bck_sync_r[SYNC_STAGES-1] & ~bck_prev_r;
      lrck_rise_r <= lrck_sync_r[SYNC_STAGES-1] & ~lrck_prev_r;
      lrck_fall_r <= ~lrck_sync_r[SYNC_STAGES-1] & lrck_prev_r;
      dat_r       <= dat_sync_r[SYNC_STAGES-1];
    end
  end

  // Channel-start decoding and the counter/skip state loaded when a new word begins
  always_comb begin
    shift_word_s = {shift_r[DATA_WIDTH-2:0], dat_r};
`ifdef AUD_RX_I2S_EN
    start_l_s    = lrck_fall_r;
    start_r_s    = lrck_rise_r;
    // A BCLK edge coincident with the LRCK edge is the skipped one
    enter_cnt_s  = '0;
    enter_skip_s = ~bck_rise_r;
`else
    start_l_s    = lrck_rise_r;
    start_r_s    = lrck_fall_r;
    // A BCLK edge coincident with the LRCK edge already carries the MSB
    enter_cnt_s  = {{(CW-1){1'b0}}, bck_rise_r};
    enter_skip_s = 1'b0;
`endif
  end

  // Framing FSM with registered sample outputs and strobes
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_r   <= ALIGN;
      shift_r   <= '0;
      hold_l_r  <= '0;
      hold_r_r  <= '0;
      cnt_r     <= '0;
      skip_r    <= 1'b0;
      bad_r     <= 1'b0;
      oAUD_inL  <= '0;
      oAUD_inR  <= '0;
      oValid    <= 1'b0;
      oFrameErr <= 1'b0;
    end else begin
      oValid    <= 1'b0;
      oFrameErr <= 1'b0;
      case (state_r)
        ALIGN: begin
          if (start_l_s) begin
            state_r <= SHIFT_L;
            cnt_r   <= enter_cnt_s;
            skip_r  <= enter_skip_s;
            bad_r   <= 1'b0;
            if (bck_rise_r) shift_r <= shift_word_s;
          end
        end
        SHIFT_L, SHIFT_R: begin
          if (start_l_s || start_r_s) begin
            // Word truncated by an early LRCK edge; a lost left word spoils the whole frame
            oFrameErr <= 1'b1;
            state_r   <= start_l_s ? SHIFT_L : SHIFT_R;
            cnt_r     <= enter_cnt_s;
            skip_r    <= enter_skip_s;
            bad_r     <= start_r_s;
            if (bck_rise_r) shift_r <= shift_word_s;
          end else if (bck_rise_r) begin
            if (skip_r) begin
              skip_r <= 1'b0;
            end else begin
              shift_r <= shift_word_s;
              cnt_r   <= cnt_r + CW'(1);
              if (cnt_r == CNT_LAST) begin
                if (state_r == SHIFT_L) begin
                  hold_l_r <= shift_word_s;
                  state_r  <= WAIT_L;
                end else begin
                  hold_r_r <= shift_word_s;
                  state_r  <= WAIT_R;
                end
              end
            end
          end
        end
        WAIT_L: begin
          if (start_r_s) begin
            state_r <= SHIFT_R;
            cnt_r   <= enter_cnt_s;
            skip_r  <= enter_skip_s;
            if (bck_rise_r) shift_r <= shift_word_s;
          end
        end
        WAIT_R: begin
          if (start_l_s) begin
            if (!bad_r) begin
              oAUD_inL <= hold_l_r;
              oAUD_inR <= hold_r_r;
              oValid   <= 1'b1;
            end
            bad_r   <= 1'b0;
            state_r <= SHIFT_L;
            cnt_r   <= enter_cnt_s;
            skip_r  <= enter_skip_s;
            if (bck_rise_r) shift_r <= shift_word_s;
          end
        end
        default: state_r <= ALIGN;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_adc_rx.sv
// Directed bench for audio_adc_rx: clean frames, truncation, reset mid-word, I2S vs left-justified.
module tb_audio_adc_rx;

  localparam int W = 16;
`ifdef AUD_RX_I2S_EN
  localparam logic LEFT_LVL   = 1'b0;
  localparam bit   NATIVE_I2S = 1'b1;
  localparam logic [W-1:0] EXP_I2S_L = 16'hBEEF;
  localparam logic [W-1:0] EXP_I2S_R = 16'hCAFE;
`else
  localparam logic LEFT_LVL   = 1'b1;
  localparam bit   NATIVE_I2S = 1'b0;
  localparam logic [W-1:0] EXP_I2S_L = 16'h657F;
  localparam logic [W-1:0] EXP_I2S_R = 16'h5F77;
`endif

  logic         clk, rst_n, bck, lrck, dat;
  logic [W-1:0] aud_l, aud_r;
  logic         valid, frame_err;

  int vec_cnt = 0, miscmp_cnt = 0;
  int valid_cnt = 0, err_cnt = 0, spur_cnt = 0;
  int v0, v1, v2;
  logic [2*W-1:0] prev_out = '0;

  audio_adc_rx #(.DATA_WIDTH(W), .SYNC_STAGES(2)) dut (
    .iCLK       (clk),
    .iRST_N     (rst_n),
    .iAUD_BCK   (bck),
    .iAUD_LRCK  (lrck),
    .iAUD_ADCDAT(dat),
    .oAUD_inL   (aud_l),
    .oAUD_inR   (aud_r),
    .oValid     (valid),
    .oFrameErr  (frame_err)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Strobe counters and a watch for outputs moving outside a valid cycle
  always @(negedge clk) begin
    if (valid) valid_cnt++;
    if (frame_err) err_cnt++;
    if (rst_n && ({aud_l, aud_r} != prev_out) && !valid) spur_cnt++;
    prev_out = {aud_l, aud_r};
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscmp_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One BCLK period (8 iCLK): data and LRCK change with the falling BCLK edge
  task automatic slot(input logic lr, input logic d);
    lrck = lr;
    dat  = d;
    bck  = 1'b0;
    repeat (4) @(negedge clk);
    bck  = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic half(input logic lr, input logic [W-1:0] w, input int nslots, input bit i2s);
    for (int s = 0; s < nslots; s++) begin
      int   k;
      logic b;
      k = i2s ? s - 1 : s;
      b = 1'b0;
      if (k >= 0 && k < W) b = w[W-1-k];
      slot(lr, b);
    end
  endtask

  task automatic frame(input logic [W-1:0] l, input logic [W-1:0] r, input bit i2s);
    logic ll;
    ll = i2s ? 1'b0 : 1'b1;
    half(ll, l, 32, i2s);
    half(~ll, r, 32, i2s);
  endtask

  task automatic native_frame(input logic [W-1:0] l, input logic [W-1:0] r);
    frame(l, r, NATIVE_I2S);
  endtask

  initial begin
    rst_n = 1'b0;
    bck   = 1'b0;
    lrck  = ~LEFT_LVL;
    dat   = 1'b0;
    repeat (5) @(negedge clk);
    check_val("rst_L", 32'(aud_l), 32'h0);
    check_val("rst_R", 32'(aud_r), 32'h0);
    check_val("rst_valid", 32'(valid), 32'h0);
    check_val("rst_err", 32'(frame_err), 32'h0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    v0 = valid_cnt;
    repeat (3) native_frame(16'hA5C3, 16'h1234);
    check_val("clean_valids", 32'(valid_cnt - v0), 32'd2);
    check_val("clean_L", 32'(aud_l), 32'h0000A5C3);
    check_val("clean_R", 32'(aud_r), 32'h00001234);

    // Left word cut short after 10 BCLKs, then a full right word
    half(LEFT_LVL, 16'hFFFF, 10, NATIVE_I2S);
    half(~LEFT_LVL, 16'h5555, 32, NATIVE_I2S);
    native_frame(16'h8000, 16'h7FFF);
    check_val("trunc_valids", 32'(valid_cnt - v0), 32'd3);
    check_val("trunc_err", 32'(err_cnt), 32'd1);
    check_val("trunc_hold_L", 32'(aud_l), 32'h0000A5C3);
    check_val("trunc_hold_R", 32'(aud_r), 32'h00001234);

    native_frame(16'h8000, 16'h7FFF);
    check_val("ext_valids", 32'(valid_cnt - v0), 32'd4);
    check_val("ext_L", 32'(aud_l), 32'h00008000);
    check_val("ext_R", 32'(aud_r), 32'h00007FFF);
    check_val("ext_err", 32'(err_cnt), 32'd1);

    // Reset 7 bits into a left word, resume mid-right-channel
    half(LEFT_LVL, 16'h1357, 7, NATIVE_I2S);
    rst_n = 1'b0;
    lrck  = ~LEFT_LVL;
    bck   = 1'b0;
    repeat (4) @(negedge clk);
    check_val("mid_rst_L", 32'(aud_l), 32'h0);
    check_val("mid_rst_R", 32'(aud_r), 32'h0);
    rst_n = 1'b1;
    v1 = valid_cnt;
    half(~LEFT_LVL, 16'hAAAA, 20, NATIVE_I2S);
    native_frame(16'h00FF, 16'hFF00);
    check_val("align_valids", 32'(valid_cnt - v1), 32'd0);
    check_val("align_L", 32'(aud_l), 32'h0);
    check_val("align_R", 32'(aud_r), 32'h0);
    native_frame(16'h00FF, 16'hFF00);
    check_val("post_rst_valids", 32'(valid_cnt - v1), 32'd1);
    check_val("post_rst_L", 32'(aud_l), 32'h000000FF);
    check_val("post_rst_R", 32'(aud_r), 32'h0000FF00);

    // Philips I2S stimulus: exact in I2S builds, one-bit shifted when received left-justified
    v2 = valid_cnt;
    repeat (3) frame(16'hBEEF, 16'hCAFE, 1'b1);
    check_val("i2s_valids", 32'(valid_cnt - v2), 32'd3);
    check_val("i2s_L", 32'(aud_l), 32'(EXP_I2S_L));
    check_val("i2s_R", 32'(aud_r), 32'(EXP_I2S_R));
    check_val("final_err", 32'(err_cnt), 32'd1);
    check_val("out_chg_wo_valid", 32'(spur_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
    $finish;
  end

endmodule

// File: doc/audio_adc_rx.md
Name: audio_adc_rx

Overview:
Serial-to-parallel receiver for the codec ADC path; the capture-side counterpart of the DAC serializer. Oversamples the codec bit clock, LR clock and ADC data in the system clock domain. Deserializes left-justified, MSB-first audio words into parallel left/right samples. Hands each completed stereo pair to the effect datapath with a one-cycle valid strobe.

Parameters:
DATA_WIDTH, 16, bits per channel word captured (MSB-first)
SYNC_STAGES, 2, synchronizer flops on each serial input (minimum 2)

Ports:
iCLK  input  1  system clock (CLOCK_50); must be at least 4x the BCLK frequency
iRST_N  input  1  asynchronous active-low reset
iAUD_BCK  input  1  codec bit clock (AUD_BCLK), asynchronous to iCLK
iAUD_LRCK  input  1  ADC LR clock (AUD_ADCLRCK); high = left channel
iAUD_ADCDAT  input  1  ADC serial data (AUD_ADCDAT)
oAUD_inL  output  DATA_WIDTH  last completed left sample, two's complement
oAUD_inR  output  DATA_WIDTH  last completed right sample, two's complement
oValid  output  1  one-iCLK pulse when oAUD_inL/oAUD_inR update
oFrameErr  output  1  one-iCLK pulse when a channel word is truncated

Behaviour:
- Reset: all synchronizers, shift register, bit counter, oAUD_inL, oAUD_inR = 0; oValid = 0; oFrameErr = 0; FSM = ALIGN.
- Synchronize all three inputs through SYNC_STAGES flops.
- BCLK rising edge = sync value 1 with previous 0. LRCK edge = any change of synced LRCK.
- Edges are detected one cycle after the last sync stage.
- FSM states:
  - ALIGN: ignore data until the first LRCK rising edge, then enter SHIFT_L. Never emit oValid from partial frames after reset.
  - SHIFT_L / SHIFT_R: on each BCLK rising edge, shift iAUD_ADCDAT into the LSB of the shift register and increment the bit counter. When counter reaches DATA_WIDTH, latch the word into the left or right hold register and enter WAIT_L or WAIT_R. Extra bits beyond DATA_WIDTH are ignored.
  - WAIT_L: on LRCK falling edge, clear the counter and enter SHIFT_R.
  - WAIT_R: on LRCK rising edge:
    - Copy both hold registers to oAUD_inL/oAUD_inR.
    - Pulse oValid in the next cycle.
    - Clear the counter and enter SHIFT_L.
- First bit: the MSB is sampled on the first BCLK rising edge after the LRCK edge (left-justified).
- Simultaneous BCLK rising edge and LRCK edge in the same iCLK cycle:
  - The LRCK transition is processed first.
  - That BCLK edge counts as bit 0 of the new word.
- Short word (LRCK edge while in SHIFT_L/SHIFT_R, counter < DATA_WIDTH):
  - Discard the partial word and pulse oFrameErr.
  - Go to SHIFT for the channel indicated by the new LRCK level.
  - A truncated left or right word suppresses that frame's oValid; outputs hold their previous values.
- Latency: oValid rises 3 iCLK cycles after the raw LRCK rising edge reaches the first sync flop (SYNC_STAGES=2). Outputs are stable from that cycle until the next oValid.
- oAUD_inL/oAUD_inR change only in the oValid cycle.
- Reset asserted mid-word: immediately return to the reset state. The next sample pair requires a fresh ALIGN.
- Counter width: clog2(DATA_WIDTH+1); saturates at DATA_WIDTH.

Optional Feature:
AUD_RX_I2S_EN
- Defined: Philips I2S format.
  - LRCK low = left, high = right.
  - MSB is sampled on the second BCLK rising edge after the LRCK edge; the first edge is skipped.
  - ALIGN waits for an LRCK falling edge.
  - WAIT_R exits on an LRCK falling edge; WAIT_L exits on an LRCK rising edge.
- Undefined: left-justified behaviour above. No skip logic is synthesized.

Test Plan:
- Reset with iRST_N=0, then drive 3 clean frames (BCLK = iCLK/8, 32 BCLKs per LRCK half): L=16'hA5C3, R=16'h1234 -> first oValid after second LRCK rising edge; oAUD_inL=16'hA5C3, oAUD_inR=16'h1234; exactly one oValid per frame.
- Signed extremes L=16'h8000, R=16'h7FFF -> outputs match bit-exact; oFrameErr stays 0.
- Start bench mid-right-channel after reset -> no oValid until one full left+right pair completes following the first LRCK rising edge.
- Toggle LRCK after only 10 left bits -> oFrameErr pulses once; oValid suppressed for that frame; outputs keep previous 16'hA5C3/16'h1234.
- Assert iRST_N low after 7 bits of a left word, release, send L=16'h00FF, R=16'hFF00 -> outputs read 0 until the first complete post-reset frame, then 16'h00FF/16'hFF00.
- With AUD_RX_I2S_EN defined, I2S-formatted L=16'hBEEF, R=16'hCAFE -> oAUD_inL=16'hBEEF, oAUD_inR=16'hCAFE; the same stimulus without the macro yields values shifted by one bit.
